// File: rtl/reg_bus_arbiter.sv
// Register-bus arbiter: grants one of NREQ requesters a single read or write on the memory bus.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index wins.
module reg_bus_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_rd,
    input  logic [NREQ-1:0]          req_wr,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          grant,
    output logic [NREQ-1:0]          done,
    output logic [NREQ-1:0]          err,
    output logic [DATA_W-1:0]        rdata,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     mem_read_q,
    output logic                     mem_write_q,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_read_dn,
    input  logic                     mem_write_dn,
    output logic                     bus_busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Timeout fires in the TMO_CYC-th WAIT cycle, when the counter is about to reach TMO_CYC.
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic             op_wr_q;
    logic [7:0]       cnt_q;

    logic [NREQ-1:0]  req_any;
    logic [NREQ-1:0]  idx_oh;
    logic [IDX_W-1:0] win;
    logic             win_vld;
    logic             dn_match;
    logic             tmo_hit;

    assign req_any = req_rd | req_wr;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q;
    int               cand;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        cand    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr_q) + k) % NREQ;
            if (!win_vld && req_any[IDX_W'(cand)]) begin
                win     = IDX_W'(cand);
                win_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (state_q == IDLE && win_vld) begin
            ptr_q <= win;
        end
    end
`else
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_any[i]) begin
                win     = IDX_W'(i);
                win_vld = 1'b1;
            end
        end
    end
`endif

    assign dn_match = op_wr_q ? mem_write_dn : mem_read_dn;
    assign tmo_hit  = (cnt_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (win_vld) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (dn_match) begin
                    state_d = DONE;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            op_wr_q   <= 1'b0;
            cnt_q     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        idx_q     <= win;
                        // A requester holding both levels is serviced as a write first.
                        op_wr_q   <= req_wr[win];
                        mem_addr  <= req_addr[int'(win)*ADDR_W +: ADDR_W];
                        mem_wdata <= req_wdata[int'(win)*DATA_W +: DATA_W];
                    end
                end
                ISSUE: begin
                    cnt_q <= '0;
                end
                WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (!op_wr_q && mem_read_dn) rdata <= mem_rdata;
                end
                default: begin
                end
            endcase
        end
    end

    assign idx_oh      = {{(NREQ-1){1'b0}}, 1'b1} << idx_q;
    assign bus_busy    = (state_q != IDLE);
    assign grant       = bus_busy ? idx_oh : '0;
    assign done        = (state_q == DONE) ? idx_oh : '0;
    assign err         = (state_q == WAIT && !dn_match && tmo_hit) ? idx_oh : '0;
    assign mem_read_q  = (state_q == ISSUE) && !op_wr_q;
    assign mem_write_q = (state_q == ISSUE) && op_wr_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: expected strobes and completions are queued by the
// stimulus and checked by independent monitors.
module tb_reg_bus_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } strb_t;

    typedef struct packed {
        logic            is_err;
        logic [NREQ-1:0] who;
        logic            is_rd;
        logic [DW-1:0]   rdata;
    } cmp_t;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_rd;
    logic [NREQ-1:0]      req_wr;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      done;
    logic [NREQ-1:0]      err;
    logic [DW-1:0]        rdata;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic                 mem_read_q;
    logic                 mem_write_q;
    logic [DW-1:0]        mem_rdata;
    logic                 mem_read_dn;
    logic                 mem_write_dn;
    logic                 bus_busy;

    int checks;
    int failures;

    strb_t sq[$];
    cmp_t  cq[$];

    int          resp_mode;   // 0: never answer, 1: answer after resp_delay, 2: wrong type first
    int          resp_delay;
    logic [DW-1:0] resp_data;
    logic        rsp_wr;

    reg_bus_arbiter #(
        .NREQ    (NREQ),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TMO_CYC (255)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .grant        (grant),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read_q   (mem_read_q),
        .mem_write_q  (mem_write_q),
        .mem_rdata    (mem_rdata),
        .mem_read_dn  (mem_read_dn),
        .mem_write_dn (mem_write_dn),
        .bus_busy     (bus_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_txn(input logic wr, input int idx, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic is_err,
                            input logic [DW-1:0] rd);
        strb_t s;
        cmp_t  c;
        s.wr     = wr;
        s.addr   = addr;
        s.wdata  = wdata;
        c.is_err = is_err;
        c.who    = NREQ'(1) << idx;
        c.is_rd  = !wr;
        c.rdata  = rd;
        sq.push_back(s);
        cq.push_back(c);
    endtask

    // Drops each requester's serviced level when its done/err arrives.
    task automatic service(input int n);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NREQ; i++) begin
                if (done[i] || err[i]) begin
                    if (req_wr[i]) req_wr[i] = 1'b0;
                    else req_rd[i] = 1'b0;
                    got++;
                end
            end
        end
        chk("service_completions", 64'(got), 64'(n));
    endtask

    // Memory responder.
    initial begin
        mem_read_dn  = 1'b0;
        mem_write_dn = 1'b0;
        mem_rdata    = '0;
        forever begin
            @(negedge clk);
            if ((mem_read_q || mem_write_q) && resp_mode != 0) begin
                rsp_wr = mem_write_q;
                if (resp_mode == 2) begin
                    @(negedge clk);
                    if (rsp_wr) mem_read_dn = 1'b1;
                    else mem_write_dn = 1'b1;
                    @(negedge clk);
                    mem_read_dn  = 1'b0;
                    mem_write_dn = 1'b0;
                end else begin
                    repeat (resp_delay) @(negedge clk);
                end
                mem_rdata = resp_data;
                if (rsp_wr) mem_write_dn = 1'b1;
                else mem_read_dn = 1'b1;
                @(negedge clk);
                mem_read_dn  = 1'b0;
                mem_write_dn = 1'b0;
            end
        end
    end

    // Strobe monitor.
    initial begin
        strb_t s;
        forever begin
            @(negedge clk);
            if (!rst && (mem_read_q || mem_write_q)) begin
                chk("strobe_exclusive", 64'(mem_read_q & mem_write_q), 64'd0);
                if (sq.size() == 0) begin
                    chk("strobe_expected", 64'(sq.size()), 64'd1);
                end else begin
                    s = sq.pop_front();
                    chk("strobe_type", 64'(mem_write_q), 64'(s.wr));
                    chk("strobe_addr", 64'(mem_addr), 64'(s.addr));
                    if (s.wr) chk("strobe_wdata", 64'(mem_wdata), 64'(s.wdata));
                end
            end
        end
    end

    // Completion monitor.
    initial begin
        cmp_t c;
        forever begin
            @(negedge clk);
            if (!rst && (|done || |err)) begin
                if (cq.size() == 0) begin
                    chk("cmp_expected", 64'(cq.size()), 64'd1);
                end else begin
                    c = cq.pop_front();
                    chk("cmp_kind", 64'(|err), 64'(c.is_err));
                    chk("cmp_vec", 64'(c.is_err ? err : done), 64'(c.who));
                    chk("cmp_grant", 64'(grant), 64'(c.who));
                    if (c.is_rd && !c.is_err) chk("cmp_rdata", 64'(rdata), 64'(c.rdata));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int order[4];

        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        req_rd     = '0;
        req_wr     = '0;
        resp_mode  = 1;
        resp_delay = 1;
        resp_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]  = 32'h100 + 32'(i * 4);
            req_wdata[i*DW +: DW] = 32'hA0 + 32'(i);
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_done_err", 64'({done, err}), 64'd0);
        chk("rst_strobes", 64'({mem_read_q, mem_write_q}), 64'd0);
        chk("rst_busy", 64'(bus_busy), 64'd0);
        chk("rst_data", 64'({rdata, mem_addr}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(bus_busy), 64'd0);

        // Minimum latency and idle gap before the next grant
        resp_data = 32'h1111;
        push_txn(1'b0, 0, 32'h100, 32'h0, 1'b0, 32'h1111);
        push_txn(1'b0, 0, 32'h100, 32'h0, 1'b0, 32'h1111);
        req_rd[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("lat_no_early_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("lat_done_4th_cycle", 64'(done), 64'b0001);
        @(negedge clk);
        chk("lat_idle_gap_grant", 64'(grant), 64'd0);
        @(negedge clk);
        chk("lat_regrant", 64'(grant), 64'b0001);
        service(1);

        // Single read, response two cycles after the strobe
        resp_delay = 2;
        resp_data  = 32'hCAFE;
        req_addr[0*AW +: AW] = 32'h10;
        push_txn(1'b0, 0, 32'h10, 32'h0, 1'b0, 32'hCAFE);
        req_rd[0] = 1'b1;
        service(1);
        req_addr[0*AW +: AW] = 32'h100;

        // Write with a stray read response first
        resp_mode = 2;
        resp_data = 32'hDEAD;
        req_wdata[2*DW +: DW] = 32'h55;
        push_txn(1'b1, 2, 32'h108, 32'h55, 1'b0, 32'h0);
        req_wr[2] = 1'b1;
        service(1);
        chk("rdata_held_after_write", 64'(rdata), 64'hCAFE);

        // Requester 3 with both levels: write, then a separate read
        resp_mode  = 1;
        resp_delay = 1;
        resp_data  = 32'h3333;
        push_txn(1'b1, 3, 32'h10C, 32'hA3, 1'b0, 32'h0);
        push_txn(1'b0, 3, 32'h10C, 32'h0, 1'b0, 32'h3333);
        req_rd[3] = 1'b1;
        req_wr[3] = 1'b1;
        service(2);

        // Four held reads from pointer 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        resp_data = 32'h4444;
`ifdef ARB_ROUND_ROBIN_EN
        order = '{1, 2, 3, 0};
`else
        order = '{0, 1, 2, 3};
`endif
        for (int i = 0; i < 4; i++) begin
            push_txn(1'b0, order[i], 32'h100 + 32'(order[i] * 4), 32'h0, 1'b0, 32'h4444);
        end
        req_rd = 4'b1111;
        service(4);

        // Timeout with no response
        resp_mode = 0;
        push_txn(1'b0, 1, 32'h104, 32'h0, 1'b1, 32'h0);
        req_rd[1] = 1'b1;
        n = 0;
        while (!mem_read_q && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_strobe_seen", 64'(mem_read_q), 64'd1);
        n = 0;
        while (err == '0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_latency", 64'(n), 64'd255);
        chk("tmo_err_vec", 64'(err), 64'b0010);
        chk("tmo_no_done", 64'(done), 64'd0);
        req_rd[1] = 1'b0;
        @(negedge clk);
        chk("tmo_busy_after", 64'(bus_busy), 64'd0);
        chk("tmo_grant_after", 64'(grant), 64'd0);

        // Reset pulsed during WAIT, request held through it
        push_txn(1'b0, 1, 32'h104, 32'h0, 1'b0, 32'h0);
        void'(cq.pop_back());
        req_rd[1] = 1'b1;
        n = 0;
        while (!mem_read_q && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rstw_strobe_seen", 64'(mem_read_q), 64'd1);
        repeat (3) @(negedge clk);
        chk("rstw_in_wait", 64'(grant), 64'b0010);
        rst = 1'b1;
        #1;
        chk("rstw_grant", 64'(grant), 64'd0);
        chk("rstw_busy", 64'(bus_busy), 64'd0);
        chk("rstw_outputs", 64'({done, err, mem_read_q, mem_write_q}), 64'd0);
        chk("rstw_regs", 64'({rdata, mem_addr}), 64'd0);
        @(negedge clk);
        chk("rstw_no_pulse", 64'({done, err}), 64'd0);
        resp_mode  = 1;
        resp_delay = 1;
        resp_data  = 32'h5555;
        push_txn(1'b0, 1, 32'h104, 32'h0, 1'b0, 32'h5555);
        rst = 1'b0;
        service(1);

        repeat (3) @(negedge clk);
        chk("sb_strobes_drained", 64'(sq.size()), 64'd0);
        chk("sb_cmp_drained", 64'(cq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
